lc3b_fetch_queue: RTL
=====================

LC3B_FETCH_QUEUE -- requirements
Module: lc3b_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of entries; power of two, minimum 2.
REQ-002 SHALL have parameter PTR_W, default $clog2(DEPTH), pointer width.
REQ-003 SHALL have clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have push, input, 1, the fetch stage offers an entry this cycle.
REQ-006 SHALL have push_pc, input, lc3b_word, PC of the offered instruction.
REQ-007 SHALL have push_ir, input, lc3b_word, the offered instruction word.
REQ-008 SHALL have push_ready, output, 1, high when a push is accepted this cycle.
REQ-009 SHALL have pop, input, 1, the decode stage consumes the head entry this cycle.
REQ-010 SHALL have head_valid, output, 1, the head entry is valid.
REQ-011 SHALL have head_pc and head_ir, output, lc3b_word each, the head entry.
REQ-012 SHALL have flush, input, 1, discard all entries (branch or jump redirect).
REQ-013 SHALL have count, output, PTR_W+1, number of valid entries.

Function
REQ-014 SHALL store entries in a circular buffer with read and write pointers of PTR_W bits that wrap from DEPTH-1 to 0.
REQ-015 SHALL accept a push when push and push_ready are both high; push_ready = (count < DEPTH) or pop.
REQ-016 SHALL retire the head when pop and head_valid are both high; pop while empty is ignored, and count does not underflow.
REQ-017 SHALL, on simultaneous accepted push and pop, advance both pointers and leave count unchanged, including when full.
REQ-018 SHALL, on push while full without pop, drop the push and hold all state.
REQ-019 SHALL drive head_pc and head_ir from the registered entry at the read pointer, with one-cycle latency from push to head_valid.
REQ-020 SHALL, on flush, zero count and set both pointers to 0 at the next edge; flush overrides push and pop in the same cycle.
REQ-021 SHALL keep push_ready low during a flush cycle.
REQ-022 SHALL hold head_pc and head_ir at 16'h0000 whenever head_valid is low.
REQ-023 SHALL keep count consistent with the pointers at all times; head_valid = (count != 0).

Reset
REQ-024 SHALL, while rst_n is low, force count=0, both pointers=0, head_valid=0, head_pc=head_ir=16'h0000, and push_ready=0.
REQ-025 SHALL raise push_ready in the first cycle after rst_n deasserts.
REQ-026 SHALL discard any in-flight push or pop when rst_n asserts mid-operation; storage contents need not be cleared.

Configuration
REQ-027 SHALL recognise the macro LC3B_FQ_BYPASS_EN.
REQ-028 SHALL, when LC3B_FQ_BYPASS_EN is defined and the queue is empty with no flush, drive head_valid, head_pc and head_ir combinationally from push and its data in the same cycle.
REQ-029 SHALL, in that bypass case, not store the entry when pop is also high; otherwise it is stored normally.
REQ-030 SHALL, without LC3B_FQ_BYPASS_EN, have no combinational path from push inputs to head outputs.

Structure
REQ-031 SHALL place a packed struct lc3b_fq_entry {lc3b_word pc; lc3b_word ir;} in lc3b_types, and use it for storage.
REQ-032 SHALL place the default constant LC3B_FQ_DEPTH = 4 in lc3b_types.
REQ-033 SHALL be a single module with no sub-modules; the storage array is inferred registers.

Verification
REQ-034 SHALL check reset: assert rst_n low mid-stream with count=3 -> count=0, head_valid=0 and head_pc=0 immediately, asynchronously.
REQ-035 SHALL check fill: DEPTH=4, push PCs 0x3000..0x3006 (step 2) on 4 cycles, no pop -> count=4, push_ready=0, and a fifth push of 0x3008 is dropped.
REQ-036 SHALL check full pass-through: at full, push 0x3008 with pop -> head becomes 0x3002 and count stays 4; after four further pops, 0x3008 emerges last.
REQ-037 SHALL check wrap-around: 10 push/pop pairs of IR values 0x1000+i -> pop order is identical, and the pointers wrap twice.
REQ-038 SHALL check flush priority: flush with push of 0x4000 and pop in the same cycle -> next cycle count=0 and head_valid=0, and 0x4000 is never output.
REQ-039 SHALL check bypass: with LC3B_FQ_BYPASS_EN, queue empty, push 0x5000 and pop in the same cycle -> head_pc=0x5000 that cycle and count stays 0; without the macro -> head_valid=0 that cycle and count=1 next.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b types for the fetch queue: the 16-bit machine word, the stored
// queue entry, and the default queue depth.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef struct packed {
        lc3b_word pc;
        lc3b_word ir;
    } lc3b_fq_entry;

    localparam int LC3B_FQ_DEPTH = 4;

endpackage

// File: rtl/lc3b_fetch_queue.sv
// LC-3b fetch queue: a circular buffer of {pc, ir} entries between fetch and
// decode. A flush discards every entry and rewinds both pointers.
//
// Optional build macro LC3B_FQ_BYPASS_EN. When it is defined and the queue
// holds no entries, an offered push drives the head outputs in the same cycle.
// If decode also pops in that cycle, the entry is consumed at once and is not
// stored. When the macro is undefined, there is no combinational path from
// the push inputs to the head outputs.
module lc3b_fetch_queue
    import lc3b_types::*;
#(
    parameter int DEPTH = LC3B_FQ_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  lc3b_word         push_pc,
    input  lc3b_word         push_ir,
    output logic             push_ready,
    input  logic             pop,
    output logic             head_valid,
    output lc3b_word         head_pc,
    output lc3b_word         head_ir,
    input  logic             flush,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    lc3b_fq_entry     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    logic stored_valid;
    logic push_fire;
    logic pop_fire;
    logic bypass;
    logic store;

    assign count = count_q;

    // Handshake decode: acceptance, retirement and whether the push is stored.
    always_comb begin
        stored_valid = (count_q != '0);
        // Flush wins over pop; reset holds off any new push.
        pop_fire     = pop && stored_valid && !flush;
        push_ready   = rst_n && !flush && ((count_q < FULL_COUNT) || pop);
        push_fire    = push && push_ready;
`ifdef LC3B_FQ_BYPASS_EN
        bypass       = push_fire && !stored_valid;
`else
        bypass       = 1'b0;
`endif
        // A bypassed entry popped in the same cycle never reaches storage.
        store        = push_fire && !(bypass && pop);
    end

    // Head outputs: stored head first, then the bypassed push, else zeros.
    always_comb begin
        head_valid = stored_valid;
        head_pc    = '0;
        head_ir    = '0;
        if (stored_valid) begin
            head_pc = mem_q[rd_ptr_q].pc;
            head_ir = mem_q[rd_ptr_q].ir;
        end
`ifdef LC3B_FQ_BYPASS_EN
        else if (bypass) begin
            head_valid = 1'b1;
            head_pc    = push_pc;
            head_ir    = push_ir;
        end
`endif
    end

    // Next-state for pointers and occupancy; pointers wrap naturally at DEPTH.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (store) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_fire) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({store, pop_fire})
                2'b10:   count_d = count_q + (PTR_W + 1)'(1);
                2'b01:   count_d = count_q - (PTR_W + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (store) begin
            mem_q[wr_ptr_q] <= '{pc: push_pc, ir: push_ir};
        end
    end

endmodule
